// File: rtl/mux_pkg.sv
// Shared helpers for the stream arbiter/mux: select-width derivation and
// round-robin pointer wrap for channel counts that need not be a power of two.
package mux_pkg;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wraps at n, not at 2**sel_width(n), so unused encodings are never reached.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above the pointer,
// wrapping modulo NUM_INPUTS; a held lock overrides the search unconditionally.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_INPUTS = 32,
  localparam int SEL_WIDTH = sel_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] i_req,
  input  logic [SEL_WIDTH-1:0]  i_ptr,
  input  logic                  i_lock_en,
  input  logic [SEL_WIDTH-1:0]  i_lock_idx,
  output logic                  o_grant_valid,
  output logic [SEL_WIDTH-1:0]  o_grant_idx
);

  localparam logic [SEL_WIDTH:0] NUM_W = (SEL_WIDTH + 1)'(NUM_INPUTS);

  logic [SEL_WIDTH:0]   w_sum;
  logic [SEL_WIDTH-1:0] w_cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_sum         = '0;
    w_cand        = '0;
    if (i_lock_en) begin
      o_grant_valid = 1'b1;
      o_grant_idx   = i_lock_idx;
    end else begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        w_sum = {1'b0, i_ptr} + (SEL_WIDTH + 1)'(k);
        if (w_sum >= NUM_W) w_sum = w_sum - NUM_W;
        w_cand = w_sum[SEL_WIDTH-1:0];
        if (i_req[w_cand]) begin
          o_grant_valid = 1'b1;
          o_grant_idx   = w_cand;
        end
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-way valid/ready stream mux: round-robin grant, optional hold until the
// packet's last beat, and a single registered output slot.
module stream_arb_mux
  import mux_pkg::*;
#(
  parameter int NUM_INPUTS   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int LOCK_ON_LAST = 1,
  localparam int SEL_WIDTH   = sel_width(NUM_INPUTS)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_INPUTS-1:0]                 in_valid_i,
  input  logic [NUM_INPUTS-1:0]                 in_last_i,
  output logic [NUM_INPUTS-1:0]                 in_ready_o,
  output logic [DATA_WIDTH-1:0]                 out_data_o,
  output logic                                  out_valid_o,
  output logic                                  out_last_o,
  output logic [SEL_WIDTH-1:0]                  out_sel_o,
  input  logic                                  out_ready_i
);

  logic [SEL_WIDTH-1:0]  r_ptr;
  logic                  r_lock;
  logic [SEL_WIDTH-1:0]  r_lock_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;
  logic [SEL_WIDTH-1:0]  r_sel;

  logic                  w_can_load;
  logic                  w_grant_valid;
  logic [SEL_WIDTH-1:0]  w_grant_idx;
  logic                  w_accept;

  rr_arbiter #(.NUM_INPUTS(NUM_INPUTS)) u_arb (
    .i_req         (in_valid_i),
    .i_ptr         (r_ptr),
    .i_lock_en     (r_lock),
    .i_lock_idx    (r_lock_idx),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_can_load = !r_valid || out_ready_i;
  assign w_accept   = rst_ni && w_grant_valid && w_can_load && in_valid_i[w_grant_idx];

  // Ready follows the grant alone, so a locked-but-idle source still sees ready.
  always_comb begin
    in_ready_o = '0;
    if (rst_ni && w_grant_valid && w_can_load) in_ready_o[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_sel      <= '0;
    end else if (w_accept) begin
      r_data  <= in_data_i[w_grant_idx];
      r_last  <= in_last_i[w_grant_idx];
      r_sel   <= w_grant_idx;
      r_valid <= 1'b1;
      if ((LOCK_ON_LAST != 0) && !in_last_i[w_grant_idx]) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant_idx;
      end else begin
        r_lock <= 1'b0;
        r_ptr  <= SEL_WIDTH'(rr_next(int'(w_grant_idx), NUM_INPUTS));
      end
    end else if (w_can_load) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data_o  = r_data;
  assign out_valid_o = r_valid;
  assign out_last_o  = r_last;
  assign out_sel_o   = r_sel;

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(in_ready_o));

  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o) &&
                                       $stable(out_last_o) && $stable(out_sel_o)));

endmodule

// File: doc/stream_arb_mux.md
Name: stream_arb_mux

Overview:
- Parametrised N-way stream multiplexer with valid/ready handshakes on every input and on the output.
- Round-robin arbitration, optional packet lock on `last`, and a registered output stage.
- Replaces the fixed 32-way combinational selector where sources are independent streams that must share one downstream consumer, such as a DMA or a bus master port.

Parameters:
- NUM_INPUTS, 32: number of input channels, any value >= 1 (power of two not required).
- DATA_WIDTH, 32: payload width in bits.
- LOCK_ON_LAST, 1: 1 = grant held until a beat with in_last_i is accepted; 0 = re-arbitrate every beat.
- SEL_WIDTH, derived: localparam = max(1, $clog2(NUM_INPUTS)).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_data_i  input  [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  per-channel payload.
- in_valid_i  input  NUM_INPUTS  per-channel valid.
- in_last_i  input  NUM_INPUTS  per-channel end-of-packet.
- in_ready_o  output  NUM_INPUTS  per-channel ready; at most one bit set.
- out_data_o  output  DATA_WIDTH  registered payload.
- out_valid_o  output  1  registered valid.
- out_last_o  output  1  registered last.
- out_sel_o  output  SEL_WIDTH  index of the source of the current output beat.
- out_ready_i  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync deassert expected):
  - out_valid_o=0, out_data_o=0, out_last_o=0, out_sel_o=0.
  - Priority pointer=0, lock flag=0.
  - in_ready_o=0 while rst_ni low.
- Output stage:
  - Single register slot; `can_load = !out_valid_o || out_ready_i`.
  - Input-to-output latency 1 cycle.
  - Full throughput: 1 beat/cycle with out_ready_i held high.
- Arbitration, when unlocked: grant = first channel with in_valid_i set, searching from pointer upward and wrapping modulo NUM_INPUTS (not 2^SEL_WIDTH). No valid channel means no grant.
- Arbitration, when locked: grant = locked index unconditionally. Other channels wait even if valid; an idle locked source stalls the mux.
- Ready: in_ready_o[grant] = can_load and grant exists. All other bits 0. Ready never depends on the granted channel's own valid.
- Accept: in_valid_i[g] && in_ready_o[g]. On accept:
  - out_data_o, out_last_o, out_sel_o are loaded and out_valid_o=1.
  - If can_load and there is no accept, out_valid_o=0 and the data registers hold their values.
- Lock (LOCK_ON_LAST=1):
  - Accept with in_last_i=0 sets lock to g.
  - Accept with in_last_i=1 clears lock and sets pointer = (g+1) mod NUM_INPUTS.
  - A single-beat packet never locks.
- LOCK_ON_LAST=0: every accept sets pointer = (g+1) mod NUM_INPUTS. Lock is never set and in_last_i is passed through only.
- Backpressure: while out_valid_o=1 and out_ready_i=0, all outputs are stable and all in_ready_o are 0.
- Simultaneous events:
  - Output drain and new accept in the same cycle: register reloads with no bubble.
  - Pointer and lock update in the same edge as the accept.
- NUM_INPUTS=1: pointer stays 0 and out_sel_o stays 0. Behaviour reduces to a one-deep pipeline register.
- Reset mid-packet: lock and the in-flight output beat are discarded; after reset, arbitration restarts from channel 0.
- Assertions: in_ready_o is one-hot-or-zero; out_* stable while out_valid_o && !out_ready_i.

Decomposition:
- Package mux_pkg:
  - `sel_width(n)` function.
  - `rr_next(ptr, n)` wrap function.
  - No width typedefs, because widths are parameter-dependent.
- Sub-module rr_arbiter (params NUM_INPUTS):
  - Inputs: req vector, pointer, lock_en, lock_idx.
  - Outputs: grant_valid, grant_idx.
  - Purely combinational.
- The parent module holds the pointer, the lock flag and the output register.

Test Plan:
- NUM_INPUTS=4, LOCK_ON_LAST=0, all valid continuously, out_ready_i=1 -> out_sel_o sequence 0,1,2,3,0,…, one beat per cycle, first out_valid_o one cycle after reset release.
- LOCK_ON_LAST=1: ch2 sends 3 beats (last on 3rd) while ch0 and ch3 stay valid -> out_sel_o=2,2,2 then 3 then 0; in_ready_o[0] and in_ready_o[3] stay 0 during the ch2 packet.
- Locked ch1 drops valid for 2 cycles mid-packet while ch0 is valid -> no output beats during the gap, then ch1 resumes, and ch0 is granted only after ch1's last.
- Backpressure: out_ready_i=0 for 5 cycles holding data 0xDEADBEEF -> out_data_o stable, in_ready_o=0; when released, the next beat follows with no bubble.
- NUM_INPUTS=5, pointer at 4, only ch4 and ch1 valid -> grant ch4, then wrap to ch1 (indices 5-7 never selected).
- Assert rst_ni low mid-packet on ch3 -> outputs clear immediately; after release, ch0 (valid) is granted before ch3.
